// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART frame transmitter: parity mode constants,
// FSM state encoding and the parity helper used at word acceptance.
package uart_tx_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Widest supported data word; narrower words are zero-extended, which
  // leaves the XOR reduction unchanged.
  localparam int unsigned MaxDataW = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } tx_state_e;

  // Parity bit for a word under the given mode. PARITY_NONE returns 0;
  // the bit is never sent in that mode.
  function automatic logic calc_parity(input logic [MaxDataW-1:0] data,
                                       input int unsigned         mode);
    logic p;
    p = 1'b0;
    if (mode == PARITY_EVEN) begin
      p = ^data;
    end else if (mode == PARITY_ODD) begin
      p = ~(^data);
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Word handshake between a producing client and the UART frame transmitter.
//   in_valid : client offers in_data
//   in_ready : transmitter can accept a word this cycle
//   in_data  : word to send
// master = client side, slave = transmitter side.
interface uart_frame_tx_if #(
  parameter int unsigned DATA_W = 7
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/uart_frame_tx_baud_tick_gen.sv
// Bit-period timer for the UART frame transmitter.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   en_i    : count while a frame is in progress
//   clear_i : restart the bit period (frame start)
//   tick_o  : one-cycle pulse in the last cycle of each bit period
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 1) begin : gen_chk_cpb
    $error("CLKS_PER_BIT must be at least 1");
  end

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Asynchronous-serial frame transmitter: start bit, LSB-first data, optional
// parity, 1 or 2 stop bits, each held CLKS_PER_BIT cycles. A word offered in
// the final stop cycle starts the next frame with no idle gap.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (aborts any frame)
//   in_if      : word handshake (slave side)
//   serial_out : serial line, idle high
//   busy       : frame in progress
module uart_frame_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W       = 7,
  parameter int unsigned PARITY       = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_tx_if.slave  in_if,
  output logic            serial_out,
  output logic            busy
);

  if (DATA_W < 5 || DATA_W > 9) begin : gen_chk_data_w
    $error("DATA_W must be in 5..9");
  end
  if (PARITY > 2) begin : gen_chk_parity
    $error("PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_chk_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : gen_chk_cpb
    $error("CLKS_PER_BIT must be at least 1");
  end

  localparam int unsigned BitCntW = $clog2(DATA_W);
  localparam logic [BitCntW-1:0] DataLast = BitCntW'(DATA_W - 1);
  localparam logic [BitCntW-1:0] StopLast = BitCntW'(STOP_BITS - 1);
  localparam logic HasParity = (PARITY != PARITY_NONE);

  tx_state_e          state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               serial_q, serial_d;
  logic               busy_q, busy_d;

  logic tick;
  logic last_stop_cycle;
  logic in_ready;
  logic accept;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != StIdle),
    .clear_i(accept),
    .tick_o (tick)
  );

  assign last_stop_cycle = (state_q == StStop) && tick && (bit_cnt_q == StopLast);
  // Kept low during reset so no word is taken while the block is held off.
  assign in_ready        = !rst && ((state_q == StIdle) || last_stop_cycle);
  assign accept          = in_if.in_valid && in_ready;
  assign in_if.in_ready  = in_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StStart;
          shift_d   = in_if.in_data;
          par_d     = calc_parity(MaxDataW'(in_if.in_data), PARITY);
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            state_d   = HasParity ? StPar : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StPar: begin
        if (tick) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = '0;
            if (accept) begin
              // Back-to-back: next start bit follows the last stop cycle.
              state_d = StStart;
              shift_d = in_if.in_data;
              par_d   = calc_parity(MaxDataW'(in_if.in_data), PARITY);
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Line level is registered from the next state so the pin is glitch-free.
    unique case (state_d)
      StStart: serial_d = 1'b0;
      StData:  serial_d = shift_d[0];
      StPar:   serial_d = par_d;
      default: serial_d = 1'b1;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with three parameterisations:
//   dut 0: defaults (7 data, even parity, 1 stop, 1 clk/bit)
//   dut 1: 8 data, odd parity
//   dut 2: 7 data, no parity, 2 stop, 4 clk/bit
module tb_uart_frame_tx;

  logic clk;
  logic rst;

  logic       v [3];
  logic [8:0] d [3];

  logic ser0, ser1, ser2;
  logic busy0, busy1, busy2;

  int checks;
  int failures;

  uart_frame_tx_if #(.DATA_W(7)) if0 ();
  uart_frame_tx_if #(.DATA_W(8)) if1 ();
  uart_frame_tx_if #(.DATA_W(7)) if2 ();

  assign if0.in_valid = v[0];
  assign if0.in_data  = d[0][6:0];
  assign if1.in_valid = v[1];
  assign if1.in_data  = d[1][7:0];
  assign if2.in_valid = v[2];
  assign if2.in_data  = d[2][6:0];

  uart_frame_tx #(
    .DATA_W(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(1)
  ) dut0 (
    .clk(clk), .rst(rst), .in_if(if0.slave), .serial_out(ser0), .busy(busy0)
  );

  uart_frame_tx #(
    .DATA_W(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_if(if1.slave), .serial_out(ser1), .busy(busy1)
  );

  uart_frame_tx #(
    .DATA_W(7), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4)
  ) dut2 (
    .clk(clk), .rst(rst), .in_if(if2.slave), .serial_out(ser2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ser(input int sel);
    case (sel)
      0:       return ser0;
      1:       return ser1;
      default: return ser2;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_rdy(input int sel);
    case (sel)
      0:       return if0.in_ready;
      1:       return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one word on an idle DUT and check every cycle of the frame.
  // exp holds the frame bits first-bit-first in its low nbits (MSB = first).
  task automatic run_frame(input int sel, input logic [8:0] data, input int nbits,
                           input int cpb, input logic [63:0] exp, input string name);
    int cyc;
    v[sel] = 1'b1;
    d[sel] = data;
    checks++;
    if (get_rdy(sel) !== 1'b1) begin
      failures++;
      $display("FAIL %s idle in_ready got %b want 1", name, get_rdy(sel));
    end
    step();
    v[sel] = 1'b0;
    d[sel] = ~data;
    cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        checks++;
        if (get_ser(sel) !== exp[nbits-1-b]) begin
          failures++;
          $display("FAIL %s bit %0d cycle %0d serial_out got %b want %b",
                   name, b, cyc, get_ser(sel), exp[nbits-1-b]);
        end
        checks++;
        if (get_busy(sel) !== 1'b1) begin
          failures++;
          $display("FAIL %s cycle %0d busy got %b want 1", name, cyc, get_busy(sel));
        end
        cyc++;
        step();
      end
    end
    checks++;
    if (get_ser(sel) !== 1'b1 || get_busy(sel) !== 1'b0) begin
      failures++;
      $display("FAIL %s after frame serial_out/busy got %b/%b want 1/0",
               name, get_ser(sel), get_busy(sel));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_ser(i) !== 1'b1 || get_busy(i) !== 1'b0 || get_rdy(i) !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d serial/busy/ready got %b/%b/%b want 1/0/0",
                 i, get_ser(i), get_busy(i), get_rdy(i));
      end
    end
    step();
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_rdy(i) !== 1'b1) begin
        failures++;
        $display("FAIL release dut%0d in_ready got %b want 1", i, get_rdy(i));
      end
    end
    step();
  endtask

  task automatic test_even_55();
    run_frame(0, 9'h055, 10, 1, 64'b0101010101, "even_55");
  endtask

  task automatic test_even_07();
    run_frame(0, 9'h007, 10, 1, 64'b0111000011, "even_07");
  endtask

  task automatic test_odd_8bit();
    run_frame(1, 9'h0A5, 11, 1, 64'b01010010111, "odd_a5");
  endtask

  task automatic test_slow_two_stop();
    run_frame(2, 9'h001, 10, 4, 64'b0100000011, "slow_2stop");
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    exp = 20'b0101010101_0010101011;
    v[0] = 1'b1;
    d[0] = 9'h055;
    step();
    d[0] = 9'h02A;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ser0 !== exp[19-i]) begin
        failures++;
        $display("FAIL b2b cycle %0d serial_out got %b want %b", i, ser0, exp[19-i]);
      end
      checks++;
      if (busy0 !== 1'b1) begin
        failures++;
        $display("FAIL b2b cycle %0d busy got %b want 1", i, busy0);
      end
      checks++;
      if (if0.in_ready !== ((i % 10) == 9)) begin
        failures++;
        $display("FAIL b2b cycle %0d in_ready got %b want %b",
                 i, if0.in_ready, ((i % 10) == 9));
      end
      step();
      if (i == 9) begin
        v[0] = 1'b0;
      end
    end
    checks++;
    if (ser0 !== 1'b1 || busy0 !== 1'b0 || if0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b end serial/busy/ready got %b/%b/%b want 1/0/1",
               ser0, busy0, if0.in_ready);
    end
  endtask

  task automatic test_mid_frame_reset();
    v[0] = 1'b1;
    d[0] = 9'h055;
    step();
    v[0] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    // Now in data bit 3 of 7'h55, which is 0.
    checks++;
    if (ser0 !== 1'b0 || busy0 !== 1'b1) begin
      failures++;
      $display("FAIL midrst bit3 serial/busy got %b/%b want 0/1", ser0, busy0);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ser0 !== 1'b1 || busy0 !== 1'b0 || if0.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst async serial/busy/ready got %b/%b/%b want 1/0/0",
               ser0, busy0, if0.in_ready);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (ser0 !== 1'b1 || busy0 !== 1'b0 || if0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst release serial/busy/ready got %b/%b/%b want 1/0/1",
               ser0, busy0, if0.in_ready);
    end
    step();
    run_frame(0, 9'h055, 10, 1, 64'b0101010101, "post_rst_55");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_even_55();
    step();
    test_even_07();
    step();
    test_odd_8bit();
    step();
    test_slow_two_stop();
    step();
    test_back_to_back();
    step();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised asynchronous-serial frame transmitter. It accepts one data word per ready/valid handshake and shifts it out on a single line as start bit, LSB-first data, optional parity bit and 1 or 2 stop bits. Each bit is held for a configurable number of clock cycles. It sits between a word-producing client and the serial pin, and supports back-to-back frames with no idle gap.

## Interface
- DATA_W, 7: data bits per frame, 5..9
- PARITY, 1: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2
- CLKS_PER_BIT, 1: clock cycles per serial bit, ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  client offers in_data
- in_ready  out  1  block can accept a word this cycle
- in_data  in  DATA_W  word to send
- serial_out  out  1  serial line, idle high
- busy  out  1  frame in progress

## Operation
- Word acceptance:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_data is captured into a shift register on that edge. Later changes to in_data have no effect.
- Parity is computed at acceptance:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
  - None: no parity bit is sent.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - serial_out=1.
  - On accept, go to START.
- START:
  - serial_out=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Send data bit i (i=0..DATA_W-1, LSB first) for CLKS_PER_BIT cycles each.
  - After bit DATA_W-1, go to PAR if PARITY≠0, otherwise go to STOP.
- PAR:
  - Send the parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - serial_out=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- Counters:
  - Baud counter: 0..CLKS_PER_BIT-1, width max(1,$clog2(CLKS_PER_BIT)), wraps at terminal count.
  - Bit counter: 0..DATA_W-1; it also counts stop bits.
- in_ready (combinational):
  - High in IDLE.
  - Also high in the final cycle of the last stop bit (baud counter at terminal count, last stop bit).
  - Forced low while rst is high.
- Accept during the final stop cycle goes directly to START. No idle cycle is inserted and busy stays high.
- busy = (state ≠ IDLE), registered with the state.
- Reset:
  - State goes to IDLE, counters to 0, serial_out=1, busy=0.
  - Takes effect immediately, including mid-frame. The aborted frame is discarded and is not resumed.
- Frame length N = 1 + DATA_W + (PARITY≠0) + STOP_BITS bits. Frame duration is N×CLKS_PER_BIT cycles.

## Timing
- Reset values: serial_out=1, busy=0, in_ready=0 while rst is high, 1 once rst is released.
- For an accept on edge k, with C = CLKS_PER_BIT:
  - Start bit drives cycles k+1..k+C.
  - Data bit i drives cycles k+1+C(1+i) .. k+C(2+i).
  - The frame ends after edge k+N×C.
- Back-to-back: the next start bit begins at cycle k+N×C+1, immediately after the last stop bit.
- busy rises on the accept edge and falls on edge k+N×C if no new word is accepted.
- Latency from accept to the first line transition is 1 cycle.

## Structure
- Package uart_tx_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state typedef.
  - Function computing the parity bit from data and mode.
- One sub-module, baud_tick_gen:
  - Contains the CLKS_PER_BIT counter.
  - Outputs a one-cycle tick at terminal count.
  - Clears on frame start.
- The FSM, shift register and bit counter live in the top module.
- Illegal parameter values are caught by elaboration-time checks.

## Test plan
- Defaults, in_data=7'h55:
  - Line reads 0,1,0,1,0,1,0,1,0,1 over 10 cycles (start, data, parity 0, stop).
  - busy is high for 10 cycles.
- Defaults, in_data=7'h07:
  - Parity bit = 1.
  - Frame reads 0,1,1,1,0,0,0,0,1,1.
- DATA_W=8, PARITY=2, in_data=8'hA5:
  - Data sent 1,0,1,0,0,1,0,1, then odd parity 1.
  - Frame is 11 bits.
- CLKS_PER_BIT=4, PARITY=0, STOP_BITS=2, in_data=7'h01:
  - Each bit is held 4 cycles.
  - Frame is 40 cycles, ending in 8 high cycles.
- Defaults, in_valid held high with 7'h55 then 7'h2A:
  - Second start bit appears in the cycle right after the first stop bit.
  - busy never drops.
  - in_ready pulses only in the final stop cycle.
- Defaults, rst asserted during data bit 3:
  - serial_out=1 and busy=0 without waiting for a clock edge.
  - After release, a new accept of 7'h55 produces the complete 10-bit frame.
